// File: rtl/voq_pkg.sv
// -----------------------------------------------------------------------------
// voq_pkg
// Shared definitions for the VOQ arbiters.
//   VOQ_NQ_MAX : largest number of queues any VOQ arbiter supports
//   voq_qid_t  : queue index wide enough for VOQ_NQ_MAX queues
//   rr_next()  : round-robin pick, first set bit of req searching upward
//                from last_ptr+1 (wrapping), last_ptr itself searched last
// -----------------------------------------------------------------------------
package voq_pkg;

  localparam int VOQ_NQ_MAX    = 16;
  localparam int VOQ_QID_MAX_W = $clog2(VOQ_NQ_MAX);

  typedef logic [VOQ_QID_MAX_W-1:0] voq_qid_t;

  // Request bits above the caller's queue count must be zero. Because
  // VOQ_NQ_MAX is a power of two, wrapping modulo VOQ_NQ_MAX then yields the
  // same pick as wrapping modulo the real queue count. Returns last_ptr when
  // req is all-zero; callers qualify the result with |req.
  function automatic voq_qid_t rr_next(input logic [VOQ_NQ_MAX-1:0] req,
                                       input voq_qid_t             last_ptr);
    voq_qid_t idx;
    rr_next = last_ptr;
    // Walk from the farthest offset to the nearest so the nearest hit wins.
    for (int k = VOQ_NQ_MAX; k >= 1; k--) begin
      idx = last_ptr + voq_qid_t'(k);
      if (req[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/voq_rr_arb.sv
// -----------------------------------------------------------------------------
// voq_rr_arb
// NQ-wide round-robin arbiter. Owns last_ptr, which resets to NQ-1 so that
// queue 0 has first priority, and moves to the granted index on every grant.
//
// Ports
//   clk        in   clock
//   rstn       in   synchronous active-low reset
//   req        in   [NQ-1:0] per-queue request
//   advance    in   grant permitted this cycle
//   grant      out  [NQ-1:0] one-hot grant, all-zero when no grant
//   grant_idx  out  [QID_W-1:0] encoded index of the pick (meaningful
//                   only when grant is non-zero)
// -----------------------------------------------------------------------------
module voq_rr_arb
  import voq_pkg::*;
#(
  parameter int NQ    = 4,
  parameter int QID_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NQ-1:0]    req,
  input  logic             advance,
  output logic [NQ-1:0]    grant,
  output logic [QID_W-1:0] grant_idx
);

  logic [QID_W-1:0]      r_last_ptr;
  logic [VOQ_NQ_MAX-1:0] w_req_ext;
  voq_qid_t              w_next;
  logic                  w_fire;
  logic                  w_unused_next;

  assign w_req_ext     = VOQ_NQ_MAX'(req);
  assign w_next        = rr_next(w_req_ext, voq_qid_t'(r_last_ptr));
  assign grant_idx     = w_next[QID_W-1:0];
  assign w_fire        = advance && (|req);
  assign w_unused_next = ^w_next;

  always_comb begin
    grant = '0;
    for (int i = 0; i < NQ; i++) begin
      grant[i] = w_fire && (grant_idx == QID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last_ptr <= QID_W'(NQ - 1);
    end else if (w_fire) begin
      r_last_ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/voq_cmd_sched.sv
// -----------------------------------------------------------------------------
// voq_cmd_sched
// Round-robin dequeue scheduler draining NQ FWFT command FIFOs into one
// registered valid/ready command stream. Double-bit-error heads are popped and
// discarded (drop_pulse); optional saturating error counters.
//
// Optional feature macro: VOQ_SCHED_ERRCNT_EN
//   defined   -> sberr_cnt, dberr_cnt, cnt_clr ports and counters exist
//   undefined -> those ports and counters are absent
//
// Ports
//   clk, rstn      clock, synchronous active-low reset
//   fifo_empty     [NQ]        per-FIFO empty (head valid when 0)
//   fifo_dout      [NQ*WIDTH]  per-FIFO head word, queue i at [i*WIDTH +: WIDTH]
//   fifo_sberr     [NQ]        head had a corrected single-bit error
//   fifo_dberr     [NQ]        head has an uncorrectable double-bit error
//   fifo_re        [NQ]        combinational pop strobe, one-hot or zero
//   q_en           [NQ]        per-queue eligibility
//   out_valid/out_data/out_qid/out_ready   output command stream
//   drop_pulse     one-cycle pulse per discarded dberr command
//   sberr_cnt, dberr_cnt, cnt_clr          counters (macro only)
//
// Handshake: a word moves on out_valid & out_ready. While out_valid=1 and
// out_ready=0, out_data and out_qid hold and no FIFO is popped. The output
// register can be reloaded whenever it is empty or being drained
// (accept = !out_valid | out_ready), giving one command per cycle.
// -----------------------------------------------------------------------------
module voq_cmd_sched
  import voq_pkg::*;
#(
  parameter int NQ    = 4,
  parameter int WIDTH = 72,
  parameter int QID_W = (NQ > 1) ? $clog2(NQ) : 1,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NQ-1:0]       fifo_empty,
  input  logic [NQ*WIDTH-1:0] fifo_dout,
  input  logic [NQ-1:0]       fifo_sberr,
  input  logic [NQ-1:0]       fifo_dberr,
  output logic [NQ-1:0]       fifo_re,
  input  logic [NQ-1:0]       q_en,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic [QID_W-1:0]    out_qid,
  input  logic                out_ready,
  output logic                drop_pulse
`ifdef VOQ_SCHED_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]    sberr_cnt,
  output logic [CNT_W-1:0]    dberr_cnt,
  input  logic                cnt_clr
`endif
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [QID_W-1:0] r_out_qid;
  logic             r_drop_pulse;

  logic             w_accept;
  logic             w_advance;
  logic [NQ-1:0]    w_elig;
  logic [NQ-1:0]    w_grant;
  logic [QID_W-1:0] w_grant_idx;
  logic             w_any_grant;
  logic             w_sel_dberr;
  logic             w_sel_sberr;
  logic [WIDTH-1:0] w_sel_data;

  assign w_accept  = !r_out_valid || out_ready;
  assign w_elig    = ~fifo_empty & q_en;
  // Gating with rstn keeps every pop strobe low while reset is held.
  assign w_advance = w_accept && rstn;

  voq_rr_arb #(
    .NQ    (NQ),
    .QID_W (QID_W)
  ) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (w_elig),
    .advance   (w_advance),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign fifo_re     = w_grant;
  assign w_any_grant = |w_grant;
  assign w_sel_dberr = |(w_grant & fifo_dberr);
  assign w_sel_sberr = |(w_grant & fifo_sberr);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NQ; i++) begin
      if (w_grant[i]) w_sel_data = fifo_dout[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_qid    <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= 1'b0;
      if (w_any_grant) begin
        if (!w_sel_dberr) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_sel_data;
          r_out_qid   <= w_grant_idx;
        end else begin
          // A grant implies the register is empty or draining, so after a
          // drop it is always empty.
          r_out_valid  <= 1'b0;
          r_drop_pulse <= 1'b1;
        end
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_qid    = r_out_qid;
  assign drop_pulse = r_drop_pulse;

`ifdef VOQ_SCHED_ERRCNT_EN
  logic [CNT_W-1:0] r_sberr_cnt;
  logic [CNT_W-1:0] r_dberr_cnt;
  logic             w_sb_evt;
  logic             w_db_evt;

  // sberr only counts when the word is forwarded; a word flagged with both
  // errors is a drop.
  assign w_sb_evt = w_any_grant && !w_sel_dberr && w_sel_sberr;
  assign w_db_evt = w_sel_dberr;

  always_ff @(posedge clk) begin
    if (!rstn || cnt_clr) begin
      r_sberr_cnt <= '0;
      r_dberr_cnt <= '0;
    end else begin
      if (w_sb_evt && (r_sberr_cnt != '1)) r_sberr_cnt <= r_sberr_cnt + 1'b1;
      if (w_db_evt && (r_dberr_cnt != '1)) r_dberr_cnt <= r_dberr_cnt + 1'b1;
    end
  end

  assign sberr_cnt = r_sberr_cnt;
  assign dberr_cnt = r_dberr_cnt;
`else
  logic w_unused_sberr;
  assign w_unused_sberr = |fifo_sberr;
`endif

endmodule

// File: tb/tb_voq_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_voq_cmd_sched
// Directed bench for voq_cmd_sched (NQ=4, WIDTH=72, CNT_W=4). A small FWFT
// FIFO model per queue feeds the DUT; expected outputs are hand-computed
// vector tables plus a scoreboard queue for the round-robin run.
// Counter checks are compiled when VOQ_SCHED_ERRCNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_voq_cmd_sched;

  localparam int NQ    = 4;
  localparam int WIDTH = 72;
  localparam int QID_W = 2;
  localparam int CNT_W = 4;
  localparam int DEPTH = 32;
  localparam int CW    = WIDTH + 8;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NQ-1:0]       fifo_empty;
  logic [NQ*WIDTH-1:0] fifo_dout;
  logic [NQ-1:0]       fifo_sberr;
  logic [NQ-1:0]       fifo_dberr;
  logic [NQ-1:0]       fifo_re;
  logic [NQ-1:0]       q_en;
  logic                out_valid;
  logic [WIDTH-1:0]    out_data;
  logic [QID_W-1:0]    out_qid;
  logic                out_ready;
  logic                drop_pulse;
`ifdef VOQ_SCHED_ERRCNT_EN
  logic [CNT_W-1:0]    sberr_cnt;
  logic [CNT_W-1:0]    dberr_cnt;
  logic                cnt_clr;
`endif

  voq_cmd_sched #(
    .NQ    (NQ),
    .WIDTH (WIDTH),
    .QID_W (QID_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_sberr (fifo_sberr),
    .fifo_dberr (fifo_dberr),
    .fifo_re    (fifo_re),
    .q_en       (q_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_qid    (out_qid),
    .out_ready  (out_ready),
    .drop_pulse (drop_pulse)
`ifdef VOQ_SCHED_ERRCNT_EN
    ,
    .sberr_cnt  (sberr_cnt),
    .dberr_cnt  (dberr_cnt),
    .cnt_clr    (cnt_clr)
`endif
  );

  // ---------------- FIFO model ----------------
  logic [WIDTH-1:0] m_data [NQ][DEPTH];
  logic             m_sb   [NQ][DEPTH];
  logic             m_db   [NQ][DEPTH];
  int               m_rd   [NQ];
  int               m_wr   [NQ];

  // ---------------- scoreboard ----------------
  logic [CW-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [NQ-1:0]    q_en;
    logic             out_ready;
    logic [NQ-1:0]    exp_re;
    logic             exp_valid;
    logic [QID_W-1:0] exp_qid;
    logic [WIDTH-1:0] exp_data;
    logic             exp_drop;
  } vec_t;

  vec_t pre_vec[1];
  vec_t mask_vec[11];
  vec_t bp_vec[8];
  vec_t ecc_vec[5];

  function automatic vec_t mkv(input logic [NQ-1:0] en, input logic rdy,
                               input logic [NQ-1:0] re, input logic v,
                               input logic [QID_W-1:0] qid,
                               input logic [WIDTH-1:0] d, input logic dp);
    vec_t r;
    r.q_en = en; r.out_ready = rdy; r.exp_re = re; r.exp_valid = v;
    r.exp_qid = qid; r.exp_data = d; r.exp_drop = dp;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] mkd(input int q, input int n);
    return WIDTH'(32'hC000 + q * 16 + n);
  endfunction

  task automatic check(input string name, input logic [CW-1:0] act,
                       input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input int q, input logic [WIDTH-1:0] d,
                      input logic sb, input logic db);
    m_data[q][m_wr[q] % DEPTH] = d;
    m_sb[q][m_wr[q] % DEPTH]   = sb;
    m_db[q][m_wr[q] % DEPTH]   = db;
    m_wr[q]++;
  endtask

  task automatic drive_heads();
    for (int q = 0; q < NQ; q++) begin
      fifo_empty[q]                 = (m_rd[q] == m_wr[q]);
      fifo_dout[q*WIDTH +: WIDTH]   = m_data[q][m_rd[q] % DEPTH];
      fifo_sberr[q]                 = m_sb[q][m_rd[q] % DEPTH] & !fifo_empty[q];
      fifo_dberr[q]                 = m_db[q][m_rd[q] % DEPTH] & !fifo_empty[q];
    end
  endtask

  // One clock: sample the pop strobe before the edge, pop the model after it.
  task automatic step(output logic [NQ-1:0] re_seen);
    drive_heads();
    #1;
    re_seen = fifo_re;
    @(posedge clk);
    #1;
    for (int q = 0; q < NQ; q++) begin
      if (re_seen[q] && (m_rd[q] != m_wr[q])) m_rd[q]++;
    end
    drive_heads();
  endtask

  task automatic reset_phase(input int cycles);
    logic [NQ-1:0] re;
    rstn = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      step(re);
      check("reset fifo_re", CW'(re), '0);
      check("reset out_valid", CW'(out_valid), '0);
      check("reset drop_pulse", CW'(drop_pulse), '0);
`ifdef VOQ_SCHED_ERRCNT_EN
      check("reset sberr_cnt", CW'(sberr_cnt), '0);
      check("reset dberr_cnt", CW'(dberr_cnt), '0);
`endif
    end
    rstn = 1'b1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [NQ-1:0] re;
    q_en      = v.q_en;
    out_ready = v.out_ready;
    step(re);
    check({tag, " fifo_re"}, CW'(re), CW'(v.exp_re));
    check({tag, " out_valid"}, CW'(out_valid), CW'(v.exp_valid));
    check({tag, " drop_pulse"}, CW'(drop_pulse), CW'(v.exp_drop));
    if (v.exp_valid) begin
      check({tag, " out_qid"}, CW'(out_qid), CW'(v.exp_qid));
      check({tag, " out_data"}, CW'(out_data), CW'(v.exp_data));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [NQ-1:0] re;
    for (int q = 0; q < NQ; q++) begin m_rd[q] = 0; m_wr[q] = 0; end
    q_en = '1; out_ready = 1'b1;
`ifdef VOQ_SCHED_ERRCNT_EN
    cnt_clr = 1'b0;
`endif
    drive_heads();

    // Vector tables (q_en, out_ready, exp fifo_re, exp valid, qid, data, drop)
    pre_vec[0]   = mkv(4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 72'h77, 1'b0);

    mask_vec[0]  = mkv(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, mkd(1, 0), 1'b0);
    mask_vec[1]  = mkv(4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, mkd(3, 0), 1'b0);
    mask_vec[2]  = mkv(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, mkd(1, 1), 1'b0);
    mask_vec[3]  = mkv(4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, mkd(3, 1), 1'b0);
    mask_vec[4]  = mkv(4'b1010, 1'b1, 4'b0000, 1'b0, 2'd0, '0, 1'b0);
    mask_vec[5]  = mkv(4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, mkd(0, 0), 1'b0);
    mask_vec[6]  = mkv(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, mkd(0, 0), 1'b0);
    mask_vec[7]  = mkv(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, mkd(2, 0), 1'b0);
    mask_vec[8]  = mkv(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, mkd(0, 1), 1'b0);
    mask_vec[9]  = mkv(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, mkd(2, 1), 1'b0);
    mask_vec[10] = mkv(4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, '0, 1'b0);

    bp_vec[0]    = mkv(4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 72'hA5, 1'b0);
    for (int i = 1; i <= 5; i++)
      bp_vec[i]  = mkv(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 72'hA5, 1'b0);
    bp_vec[6]    = mkv(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 72'hB6, 1'b0);
    bp_vec[7]    = mkv(4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, '0, 1'b0);

    ecc_vec[0]   = mkv(4'b1111, 1'b1, 4'b0100, 1'b0, 2'd0, '0, 1'b1);
    ecc_vec[1]   = mkv(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 72'hE3, 1'b0);
    ecc_vec[2]   = mkv(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 72'h5B, 1'b0);
    ecc_vec[3]   = mkv(4'b1111, 1'b1, 4'b1000, 1'b0, 2'd0, '0, 1'b1);
    ecc_vec[4]   = mkv(4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, '0, 1'b0);

    // Reset with every FIFO holding 3 commands, then round-robin drain.
    for (int n = 0; n < 3; n++)
      for (int q = 0; q < NQ; q++) begin
        push(q, mkd(q, n), 1'b0, 1'b0);
        exp_q.push_back({6'd0, QID_W'(q), mkd(q, n)});
      end
    reset_phase(3);

    step(re);
    check("rr first fifo_re", CW'(re), CW'(4'b0001));
    check("rr out_valid 0", CW'(out_valid), CW'(1'b1));
    check("rr word 0", CW'({out_qid, out_data}), exp_q.pop_front());
    for (int c = 1; c < 12; c++) begin
      step(re);
      check("rr out_valid", CW'(out_valid), CW'(1'b1));
      if (exp_q.size() > 0) check("rr word", CW'({out_qid, out_data}), exp_q.pop_front());
    end
    step(re);
    check("rr drained out_valid", CW'(out_valid), '0);
    check("rr scoreboard empty", CW'(exp_q.size()), '0);

    // Masking and a short backpressure, all queues with 2 commands.
    for (int n = 0; n < 2; n++)
      for (int q = 0; q < NQ; q++) push(q, mkd(q, n), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) apply(mask_vec[i], $sformatf("mask[%0d]", i));

    // Load the output register, then reset mid-operation.
    push(3, 72'h77, 1'b0, 1'b0);
    apply(pre_vec[0], "pre_reset");
    reset_phase(2);

    // Backpressure: A5 held for 5 cycles, B6 issued once out_ready rises.
    push(0, 72'hA5, 1'b0, 1'b0);
    push(1, 72'hB6, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) apply(bp_vec[i], $sformatf("bp[%0d]", i));

    // ECC: drop, forward, sberr forward, drop while draining.
    push(2, 72'hD0, 1'b0, 1'b1);
    push(2, 72'h5B, 1'b1, 1'b0);
    push(3, 72'hE3, 1'b0, 1'b0);
    push(3, 72'hD3, 1'b0, 1'b1);
    apply(ecc_vec[0], "ecc[0]");
`ifdef VOQ_SCHED_ERRCNT_EN
    check("ecc dberr_cnt 1", CW'(dberr_cnt), CW'(4'd1));
    check("ecc sberr_cnt 0", CW'(sberr_cnt), CW'(4'd0));
`endif
    apply(ecc_vec[1], "ecc[1]");
    apply(ecc_vec[2], "ecc[2]");
`ifdef VOQ_SCHED_ERRCNT_EN
    check("ecc sberr_cnt 1", CW'(sberr_cnt), CW'(4'd1));
`endif
    apply(ecc_vec[3], "ecc[3]");
    apply(ecc_vec[4], "ecc[4]");
`ifdef VOQ_SCHED_ERRCNT_EN
    check("ecc dberr_cnt 2", CW'(dberr_cnt), CW'(4'd2));

    // Saturation: 20 more drops on a 4-bit counter, then clear with a drop.
    for (int i = 0; i < 20; i++) push(1, 72'h0, 1'b0, 1'b1);
    q_en = '1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step(re);
    check("sat dberr_cnt", CW'(dberr_cnt), CW'(4'd15));
    check("sat drop_pulse", CW'(drop_pulse), CW'(1'b1));
    push(1, 72'h0, 1'b0, 1'b1);
    cnt_clr = 1'b1;
    step(re);
    cnt_clr = 1'b0;
    check("clr fifo_re", CW'(re), CW'(4'b0010));
    check("clr dberr_cnt", CW'(dberr_cnt), '0);
    check("clr sberr_cnt", CW'(sberr_cnt), '0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
